// File: rtl/axi_slave_wr_ctrl.sv
// AXI3 write slave: AW -> W beats -> B, one burst at a time, beats become byte-addressed SRAM writes.
// Latency: a W handshake appears on mem_we/mem_addr/mem_wdata/mem_wstrb one cycle later; all outputs are registered.
// Backpressure: W is never stalled; awready is low until one cycle after the B handshake. AXI_WR_PROTO_CHECK_EN enables wid/wlast/WRAP-length checks.
module axi_slave_wr_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                  aclk,
    input  logic                  arst,
    input  logic [ID_W-1:0]       awid,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [3:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ID_W-1:0]       wid,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_W-1:0]       bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb
);
    localparam int NB     = DATA_W / 8;
    localparam int NB_LOG = $clog2(NB);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t              state, state_n;
    logic [ID_W-1:0]     id_q, id_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [3:0]          len_q, len_n;
    logic [2:0]          size_q, size_n;
    logic [1:0]          burst_q, burst_n;
    logic                err_q, err_n;
    logic                aw_err_q, aw_err_n;
    logic [4:0]          cnt_q, cnt_n;

    logic                awready_n, wready_n, bvalid_n, mem_we_n;
    logic [ID_W-1:0]     bid_n;
    logic [1:0]          bresp_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [DATA_W-1:0]   mem_wdata_n;
    logic [NB-1:0]       mem_wstrb_n;

    logic [ADDR_W-1:0]   step, wrap_mask, addr_adv;
    logic                aw_err_c, wrap_len_err, beat_err, last_beat;

`ifdef AXI_WR_PROTO_CHECK_EN
    assign wrap_len_err = !(awlen inside {4'd1, 4'd3, 4'd7, 4'd15});
    assign beat_err     = (wid != id_q)
                        || (wlast && (cnt_q != {1'b0, len_q}))
                        || (cnt_q > {1'b0, len_q});
    assign last_beat    = wlast;
`else
    logic unused_proto;
    assign unused_proto = ^{wid, wlast};
    assign wrap_len_err = 1'b0;
    assign beat_err     = 1'b0;
    assign last_beat    = (cnt_q == {1'b0, len_q});
`endif

    assign aw_err_c = (awsize > 3'(NB_LOG))
                   || (awburst == 2'b11)
                   || ((awburst == 2'b10) && wrap_len_err);

    // WRAP stays inside the (len+1)<<size block the current address already sits in
    always_comb begin
        step      = ADDR_W'(1) << size_q;
        wrap_mask = (({{(ADDR_W-4){1'b0}}, len_q} + ADDR_W'(1)) << size_q) - ADDR_W'(1);
        case (burst_q)
            2'b00:   addr_adv = addr_q;
            2'b10:   addr_adv = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default: addr_adv = addr_q + step;
        endcase
    end

    always_comb begin
        state_n     = state;
        id_n        = id_q;
        addr_n      = addr_q;
        len_n       = len_q;
        size_n      = size_q;
        burst_n     = burst_q;
        err_n       = err_q;
        aw_err_n    = aw_err_q;
        cnt_n       = cnt_q;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        mem_wstrb_n = mem_wstrb;

        case (state)
            IDLE: begin
                if (awvalid && awready) begin
                    id_n     = awid;
                    addr_n   = awaddr;
                    len_n    = awlen;
                    size_n   = awsize;
                    burst_n  = awburst;
                    err_n    = aw_err_c;
                    aw_err_n = aw_err_c;
                    cnt_n    = 5'd0;
                    state_n  = DATA;
                end
            end
            DATA: begin
                if (wvalid && wready) begin
                    mem_we_n    = !aw_err_q && !beat_err;
                    mem_addr_n  = addr_q & ~(step - ADDR_W'(1));
                    mem_wdata_n = wdata;
                    mem_wstrb_n = wstrb;
                    addr_n      = addr_adv;
                    err_n       = err_q | beat_err;
                    // saturate so a runaway burst keeps flagging beats beyond len
                    cnt_n       = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
                    if (last_beat)
                        state_n = RESP;
                end
            end
            RESP: begin
                if (bvalid && bready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        awready_n = (state_n == IDLE);
        wready_n  = (state_n == DATA);
        bvalid_n  = (state_n == RESP);
        bid_n     = (state_n == RESP) ? id_n : '0;
        bresp_n   = (state_n == RESP) ? {err_n, 1'b0} : 2'b00;
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state     <= IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            aw_err_q  <= 1'b0;
            cnt_q     <= '0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            bresp     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            state     <= state_n;
            id_q      <= id_n;
            addr_q    <= addr_n;
            len_q     <= len_n;
            size_q    <= size_n;
            burst_q   <= burst_n;
            err_q     <= err_n;
            aw_err_q  <= aw_err_n;
            cnt_q     <= cnt_n;
            awready   <= awready_n;
            wready    <= wready_n;
            bvalid    <= bvalid_n;
            bid       <= bid_n;
            bresp     <= bresp_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            mem_wstrb <= mem_wstrb_n;
        end
    end
endmodule

// File: tb/tb_axi_slave_wr_ctrl.sv
// Randomized scoreboard bench for axi_slave_wr_ctrl: driver pushes expected SRAM writes and B responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_axi_slave_wr_ctrl;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int NB     = 4;

    logic              aclk = 1'b0;
    logic              arst = 1'b1;
    logic [ID_W-1:0]   awid = '0;
    logic [ADDR_W-1:0] awaddr = '0;
    logic [3:0]        awlen = '0;
    logic [2:0]        awsize = '0;
    logic [1:0]        awburst = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [ID_W-1:0]   wid = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [NB-1:0]     wstrb = '0;
    logic              wlast = 1'b0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_wstrb;

    always #5 aclk = ~aclk;

    axi_slave_wr_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .aclk(aclk), .arst(arst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;

    wr_t wq[$];
    b_t  bq[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t mon_w;
    b_t  mon_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out after 50 cycles waiting for DUT", name);
    endtask

    // Byte address of beat i, straight from the burst definitions
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input int size, input int burst, input int i);
        logic [31:0] step, bnd, base, a;
        step = 32'd1 << size;
        case (burst)
            0: a = start;
            2: begin
                bnd  = 32'(len + 1) * step;
                base = start - (start % bnd);
                a    = base + ((start - base + 32'(i) * step) % bnd);
            end
            default: a = start + 32'(i) * step;
        endcase
        return a - (a % step);
    endfunction

    always @(negedge aclk) begin
        if (mem_we) begin
            if (wq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: mem_we=1 at addr %h, required no write", mem_addr);
            end else begin
                mon_w = wq.pop_front();
                check("mem_addr",  64'(mem_addr),  64'(mon_w.addr));
                check("mem_wdata", 64'(mem_wdata), 64'(mon_w.data));
                check("mem_wstrb", 64'(mem_wstrb), 64'(mon_w.strb));
            end
        end
        if (bvalid && bready) begin
            if (bq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_b: bvalid handshake with bid %h, required none", bid);
            end else begin
                mon_b = bq.pop_front();
                check("bid",   64'(bid),   64'(mon_b.id));
                check("bresp", 64'(bresp), 64'(mon_b.resp));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"},   64'(awready),   64'd0);
        check({tag, "_wready"},    64'(wready),    64'd0);
        check({tag, "_bvalid"},    64'(bvalid),    64'd0);
        check({tag, "_bid"},       64'(bid),       64'd0);
        check({tag, "_bresp"},     64'(bresp),     64'd0);
        check({tag, "_mem_we"},    64'(mem_we),    64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_mem_wstrb"}, 64'(mem_wstrb), 64'd0);
    endtask

    // mode (protocol-check build): 0 clean, 1 wrong wid on one beat, 2 early wlast, 3 extra beats
    task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst, input int mode, input int bhold,
                            input int abort_after, input int strb_fix);
        logic [3:0]  b_id  [18];
        logic        b_last[18];
        logic [31:0] b_dat [18];
        logic [3:0]  b_stb [18];
        int          nb, to;
        bit          aw_err, any_err, berr, pre;
        logic [1:0]  exp_resp;
        wr_t         ew;
        b_t          eb;

        nb = len + 1;
        for (int i = 0; i < 18; i++) begin
            b_id[i]   = id;
            b_last[i] = (i == len);
            b_dat[i]  = $urandom;
            b_stb[i]  = (strb_fix >= 0) ? 4'(strb_fix) : 4'($urandom);
        end
`ifdef AXI_WR_PROTO_CHECK_EN
        if (mode == 1) begin
            b_id[$urandom_range(0, len)] = id ^ 4'h1;
        end else if (mode == 2 && len >= 1) begin
            b_last[len]      = 1'b0;
            b_last[len >> 1] = 1'b1;
            nb               = (len >> 1) + 1;
        end else if (mode == 3) begin
            nb              = len + 1 + int'($urandom_range(1, 2));
            b_last[len]     = 1'b0;
            b_last[nb - 1]  = 1'b1;
        end
        aw_err = (size > 2) || (burst == 3) || (burst == 2 && !(len inside {1, 3, 7, 15}));
`else
        if (mode != 0) begin
            for (int i = 0; i < 18; i++) begin
                b_id[i]   = 4'($urandom);
                b_last[i] = 1'($urandom);
            end
        end
        aw_err = (size > 2) || (burst == 3);
`endif
        any_err = aw_err;
        for (int i = 0; i < nb; i++) begin
`ifdef AXI_WR_PROTO_CHECK_EN
            berr = (b_id[i] != id) || (b_last[i] && i != len) || (i > len);
`else
            berr = 1'b0;
`endif
            any_err = any_err | berr;
            if ((abort_after < 0 || i < abort_after) && !aw_err && !berr) begin
                ew.addr = beat_addr(addr, len, size, burst, i);
                ew.data = b_dat[i];
                ew.strb = b_stb[i];
                wq.push_back(ew);
            end
        end
        exp_resp = any_err ? 2'b10 : 2'b00;
        if (abort_after < 0) begin
            eb.id   = id;
            eb.resp = exp_resp;
            bq.push_back(eb);
        end

        @(posedge aclk); #1;
        awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1'b1;
        pre = 1'($urandom);
        if (pre) begin
            wid = b_id[0]; wdata = b_dat[0]; wstrb = b_stb[0]; wlast = b_last[0]; wvalid = 1'b1;
        end
        to = 0;
        do begin @(negedge aclk); to++; end while (!awready && to < 50);
        if (!awready) begin timeout_fail("aw_handshake"); awvalid = 1'b0; wvalid = 1'b0; return; end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        awaddr  = $urandom;

        for (int i = 0; i < nb; i++) begin
            if (i == abort_after) begin
                arst = 1'b1;
                @(posedge aclk);
                @(negedge aclk);
                check_all_zero("rst_mid");
                @(posedge aclk); #1;
                arst = 1'b0;
                repeat (3) begin
                    @(negedge aclk);
                    check("no_bvalid_after_rst", 64'(bvalid), 64'd0);
                end
                return;
            end
            if (!(i == 0 && pre)) begin
                repeat ($urandom_range(0, 1)) begin @(posedge aclk); #1; end
                wid = b_id[i]; wdata = b_dat[i]; wstrb = b_stb[i]; wlast = b_last[i]; wvalid = 1'b1;
            end
            to = 0;
            do begin @(negedge aclk); to++; end while (!wready && to < 50);
            if (!wready) begin timeout_fail("w_handshake"); wvalid = 1'b0; return; end
            @(posedge aclk); #1;
            wvalid = 1'b0;
        end

        to = 0;
        do begin @(negedge aclk); to++; end while (!bvalid && to < 50);
        if (!bvalid) begin timeout_fail("bvalid_wait"); return; end
        for (int j = 0; j < bhold; j++) begin
            @(negedge aclk);
            check("bvalid_hold",  64'(bvalid),  64'd1);
            check("bid_hold",     64'(bid),     64'(id));
            check("bresp_hold",   64'(bresp),   64'(exp_resp));
            check("awready_hold", 64'(awready), 64'd0);
        end
        @(posedge aclk); #1;
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        @(negedge aclk);
        check("awready_after_b", 64'(awready), 64'd1);
        check("bvalid_after_b",  64'(bvalid),  64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wl[4];
        int len, size, burst;
        logic [31:0] addr;
        wl = '{1, 3, 7, 15};

        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check_all_zero("rst");
        @(posedge aclk); #1;
        arst = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check("awready_after_rst", 64'(awready), 64'd1);
        check("wready_after_rst",  64'(wready),  64'd0);

        do_burst(4'h5, 32'h100, 3, 2, 1, 0, 0, -1, -1);
        do_burst(4'h6, 32'h38,  3, 2, 2, 0, 0, -1, -1);
        do_burst(4'h7, 32'h20,  2, 2, 0, 0, 0, -1, 3);
        do_burst(4'h9, 32'h200, 1, 2, 1, 0, 5, -1, -1);
        do_burst(4'hA, 32'h300, 3, 2, 1, 2, 1, -1, -1);
        do_burst(4'hB, 32'h400, 3, 2, 3, 0, 0, -1, -1);
        do_burst(4'hC, 32'h500, 2, 3, 1, 0, 0, -1, -1);
        do_burst(4'hD, 32'hFFFF_FFF8, 3, 2, 1, 0, 0, -1, -1);
        do_burst(4'h3, 32'h600, 3, 2, 1, 0, 0, 2, -1);
        do_burst(4'h4, 32'h700, 3, 2, 1, 0, 0, -1, -1);

        for (int r = 0; r < 40; r++) begin
            len   = int'($urandom_range(0, 15));
            size  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
            burst = int'($urandom_range(0, 3));
`ifndef AXI_WR_PROTO_CHECK_EN
            if (burst == 2) len = wl[$urandom_range(0, 3)];
`endif
            addr = $urandom;
            if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFF0 | ($urandom & 32'hC);
            do_burst(4'($urandom), addr, len, size, burst, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), -1, -1);
        end

        repeat (3) @(negedge aclk);
        check("write_queue_drained", 64'(wq.size()), 64'd0);
        check("b_queue_drained",     64'(bq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
